counter_modn_bounded: RTL and testbench

Parametrised successor to the alarm clock's mod-N up/down counter. Holds a value in an arbitrary closed range [MIN, MAX] rather than [0, N-1], with selectable wrap or saturate behaviour. It adds a count enable, clamped load, and carry/borrow outputs for cascading seconds→minutes→hours. A compile-time option adds an auto-repeat engine so held set-buttons step the value continuously.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/counter_repeat_fsm.sv | 100 ++++++++++
 rtl/counter_modn_bounded.sv | 97 +++++++++
 tb/tb_counter_modn_bounded.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock counters: repeat FSM states,
// standard time-field ranges and the repeat tick-counter width helper.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      DELAY  = 2'd2,
      REPEAT = 2'd3
   } rep_state_t;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HR12_MIN = 1;
   localparam int HR12_MAX = 12;

   localparam int REP_DLY_DEF = 8;
   localparam int REP_PER_DEF = 2;

   // The tick counter only ever holds 0 .. max(dly, per)-1.
   function automatic int tick_cnt_w(input int dly, input int per);
      int m;
      m = (dly > per) ? dly : per;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   localparam int TICK_W = tick_cnt_w(REP_DLY_DEF, REP_PER_DEF);

endpackage

// File: rtl/counter_repeat_fsm.sv
// Auto-repeat engine: turns a held set-button into single-cycle step pulses
// (one on press, one after REP_DLY ticks, then one every REP_PER ticks).
module counter_repeat_fsm
   import clock_pkg::*;
#(
   parameter int REP_DLY = 8,
   parameter int REP_PER = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic btn_up,
   input  logic btn_dn,
   output logic rep_up,
   output logic rep_dn
);

   localparam int CW = tick_cnt_w(REP_DLY, REP_PER);
   localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);

   rep_state_t      state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            dir_reg, dir_next;
   logic            btn_reg;
   logic            btn;
   logic            pulse;

   // Both buttons high reads as "no button", which forces an exit.
   assign btn = btn_up ^ btn_dn;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         dir_reg   <= 1'b0;
         btn_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         dir_reg   <= dir_next;
         btn_reg   <= btn;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      dir_next   = dir_reg;
      pulse      = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (btn && !btn_reg) begin
               state_next = FIRST;
               dir_next   = btn_up;
            end
         end
         FIRST: begin
            if (!btn) begin
               state_next = IDLE;
            end else begin
               pulse      = 1'b1;
               state_next = DELAY;
               cnt_next   = '0;
            end
         end
         DELAY: begin
            if (!btn) begin
               state_next = IDLE;
            end else if (tick) begin
               if (cnt_reg == DLY_LAST) begin
                  pulse      = 1'b1;
                  state_next = REPEAT;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         REPEAT: begin
            if (!btn) begin
               state_next = IDLE;
            end else if (tick) begin
               if (cnt_reg == PER_LAST) begin
                  pulse    = 1'b1;
                  cnt_next = '0;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign rep_up = pulse &  dir_reg;
   assign rep_dn = pulse & ~dir_reg;

endmodule

// File: rtl/counter_modn_bounded.sv
// Bounded [MIN, MAX] up/down counter with wrap or saturate, clamped load and
// same-cycle carry/borrow for cascading. AUTO_REPEAT_EN adds the button repeat engine.
module counter_modn_bounded
   import clock_pkg::*;
#(
   parameter int W       = 6,
   parameter int MIN     = 0,
   parameter int MAX     = SEC_MAX,
   parameter int WRAP    = 1,
   parameter int REP_DLY = REP_DLY_DEF,
   parameter int REP_PER = REP_PER_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         up,
   input  logic         down,
   input  logic         load,
   input  logic [W-1:0] data,
`ifdef AUTO_REPEAT_EN
   input  logic         tick,
   input  logic         btn_up,
   input  logic         btn_dn,
`endif
   output logic [W-1:0] count,
   output logic         carry,
   output logic         borrow,
   output logic         at_min,
   output logic         at_max
);

   localparam logic [W-1:0] LO = W'(MIN);
   localparam logic [W-1:0] HI = W'(MAX);
   localparam logic         WRAP_EN = (WRAP != 0);

   if (!(MIN >= 0 && MIN < MAX && MAX < (2 ** W))) begin : g_bad_range
      $error("counter_modn_bounded: need 0 <= MIN < MAX < 2**W");
   end
   if (REP_DLY < 1 || REP_PER < 1) begin : g_bad_repeat
      $error("counter_modn_bounded: REP_DLY and REP_PER must be at least 1");
   end

   logic         rep_up, rep_dn;
   logic         inc, dec;
   logic [W-1:0] count_reg, count_next;
   logic [W-1:0] data_clamped;

`ifdef AUTO_REPEAT_EN
   counter_repeat_fsm #(
      .REP_DLY (REP_DLY),
      .REP_PER (REP_PER)
   ) u_repeat (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .btn_up  (btn_up),
      .btn_dn  (btn_dn),
      .rep_up  (rep_up),
      .rep_dn  (rep_dn)
   );
`else
   assign rep_up = 1'b0;
   assign rep_dn = 1'b0;
`endif

   assign inc    = (en & up)   | rep_up;
   assign dec    = (en & down) | rep_dn;
   assign at_min = (count_reg == LO);
   assign at_max = (count_reg == HI);
   assign carry  = inc & ~dec & ~load & at_max & WRAP_EN;
   assign borrow = dec & ~inc & ~load & at_min & WRAP_EN;
   assign count  = count_reg;

   // Compare before use so out-of-range loads never reach the register.
   assign data_clamped = (data < LO) ? LO : ((data > HI) ? HI : data);

   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = data_clamped;
      end else if (inc && dec) begin
         count_next = count_reg;
      end else if (inc) begin
         if (at_max) count_next = WRAP_EN ? LO : count_reg;
         else        count_next = count_reg + W'(1);
      end else if (dec) begin
         if (at_min) count_next = WRAP_EN ? HI : count_reg;
         else        count_next = count_reg - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) count_reg <= LO;
      else          count_reg <= count_next;
   end

endmodule

// File: tb/tb_counter_modn_bounded.sv
// Directed bench: a 1..12 wrapping instance and a 0..59 saturating instance;
// the auto-repeat sequence runs only when AUTO_REPEAT_EN is defined.
module tb_counter_modn_bounded;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;

   logic       a_en, a_up, a_dn, a_load;
   logic [3:0] a_data, a_count;
   logic       a_carry, a_borrow, a_min, a_max;

   logic       b_en, b_up, b_dn, b_load;
   logic [5:0] b_data, b_count;
   logic       b_carry, b_borrow, b_min, b_max;

`ifdef AUTO_REPEAT_EN
   logic       b_tick, b_bu, b_bd;
   logic       a_zero;
   assign a_zero = 1'b0;
`endif

   int vectors     = 0;
   int miscompares = 0;

   counter_modn_bounded #(.W(4), .MIN(1), .MAX(12), .WRAP(1)) u_a (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (a_en),
      .up      (a_up),
      .down    (a_dn),
      .load    (a_load),
      .data    (a_data),
`ifdef AUTO_REPEAT_EN
      .tick    (a_zero),
      .btn_up  (a_zero),
      .btn_dn  (a_zero),
`endif
      .count   (a_count),
      .carry   (a_carry),
      .borrow  (a_borrow),
      .at_min  (a_min),
      .at_max  (a_max)
   );

   counter_modn_bounded #(.W(6), .MIN(0), .MAX(59), .WRAP(0),
                          .REP_DLY(8), .REP_PER(2)) u_b (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (b_en),
      .up      (b_up),
      .down    (b_dn),
      .load    (b_load),
      .data    (b_data),
`ifdef AUTO_REPEAT_EN
      .tick    (b_tick),
      .btn_up  (b_bu),
      .btn_dn  (b_bd),
`endif
      .count   (b_count),
      .carry   (b_carry),
      .borrow  (b_borrow),
      .at_min  (b_min),
      .at_max  (b_max)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      {a_en, a_up, a_dn, a_load} = '0; a_data = '0;
      {b_en, b_up, b_dn, b_load} = '0; b_data = '0;
`ifdef AUTO_REPEAT_EN
      b_tick = 1'b1; b_bu = 1'b0; b_bd = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_a_count", a_count, 1);
      chk("rst_b_count", b_count, 0);
      chk("rst_a_at_min", a_min, 1);
      chk("rst_a_carry", a_carry, 0);
      chk("rst_a_borrow", a_borrow, 0);
      reset_n = 1'b1;

      // Wrapping instance, range 1..12
      a_load = 1; a_data = 4'd12;
      @(posedge clk); #1;
      chk("a_load12", a_count, 12);
      chk("a_at_max", a_max, 1);
      a_load = 0; a_en = 1; a_up = 1;
      @(negedge clk);
      chk("a_carry_at_max", a_carry, 1);
      chk("a_borrow_on_up", a_borrow, 0);
      @(posedge clk); #1;
      chk("a_wrap_to_min", a_count, 1);
      chk("a_at_min", a_min, 1);
      a_up = 0; a_dn = 1;
      @(negedge clk);
      chk("a_borrow_at_min", a_borrow, 1);
      chk("a_carry_on_dn", a_carry, 0);
      @(posedge clk); #1;
      chk("a_wrap_to_max", a_count, 12);
      a_en = 0; a_dn = 0; a_load = 1; a_data = 4'd0;
      @(posedge clk); #1;
      chk("a_load_below_min", a_count, 1);
      a_data = 4'd15;
      @(posedge clk); #1;
      chk("a_load_above_max", a_count, 12);
      a_data = 4'd5; a_en = 1; a_up = 1;
      @(negedge clk);
      chk("a_carry_with_load", a_carry, 0);
      @(posedge clk); #1;
      chk("a_load_beats_up", a_count, 5);
      a_load = 0; a_dn = 1;
      @(negedge clk);
      chk("a_both_carry", a_carry, 0);
      chk("a_both_borrow", a_borrow, 0);
      @(posedge clk); #1;
      chk("a_both_hold", a_count, 5);
      a_en = 0; a_dn = 0;
      @(posedge clk); #1;
      chk("a_en0_hold", a_count, 5);
      a_en = 1;
      @(posedge clk); #1;
      chk("a_up_mid", a_count, 6);
      a_dn = 1; a_up = 0;
      @(posedge clk); #1;
      chk("a_dn_mid", a_count, 5);
      {a_en, a_up, a_dn} = '0;

      // Saturating instance, range 0..59
      b_load = 1; b_data = 6'd63;
      @(posedge clk); #1;
      chk("b_load63", b_count, 59);
      b_load = 0; b_en = 1; b_up = 1;
      @(negedge clk);
      chk("b_no_carry_sat", b_carry, 0);
      @(posedge clk); #1;
      chk("b_sat_max", b_count, 59);
      b_en = 0; b_up = 0; b_load = 1; b_data = 6'd0;
      @(posedge clk); #1;
      chk("b_load0", b_count, 0);
      b_load = 0; b_en = 1; b_dn = 1;
      @(negedge clk);
      chk("b_no_borrow_sat", b_borrow, 0);
      @(posedge clk); #1;
      chk("b_sat_min", b_count, 0);
      b_dn = 0; b_up = 1;
      @(posedge clk); #1;
      chk("b_up_from0", b_count, 1);
      {b_en, b_up} = '0;

      // Asynchronous reset between edges
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("async_rst_a", a_count, 1);
      chk("async_rst_b", b_count, 0);
      @(negedge clk);
      reset_n = 1'b1;

`ifdef AUTO_REPEAT_EN
      @(posedge clk); #1;
      b_bu = 1;
      @(posedge clk); #1;
      chk("rep_e0", b_count, 0);
      @(posedge clk); #1;
      chk("rep_first_step", b_count, 1);
      repeat (7) @(posedge clk);
      #1;
      chk("rep_in_delay", b_count, 1);
      @(posedge clk); #1;
      chk("rep_after_delay", b_count, 2);
      repeat (10) @(posedge clk);
      #1;
      chk("rep_held20", b_count, 7);
      b_bu = 0;
      repeat (5) @(posedge clk);
      #1;
      chk("rep_released", b_count, 7);

      b_load = 1; b_data = 6'd35;
      @(posedge clk); #1;
      b_load = 0;
      chk("rep_load35", b_count, 35);
      b_bu = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("rep_at37", b_count, 37);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rep_async_rst", b_count, 0);
      b_bu = 0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rep_no_step_after_rst", b_count, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
